// File: rtl/lcd_pkg.sv
// Shared HD44780 command bytes and FSM state encodings.
// Also used by the ASCII formatters that feed the character driver.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
  localparam logic [7:0] LCD_LINE1     = 8'h80;
  localparam logic [7:0] LCD_LINE2     = 8'hC0;
  localparam logic [7:0] LCD_SPACE     = 8'h20;

  typedef enum logic [3:0] {
    S_DELAY   = 4'd0,
    S_FUNC    = 4'd1,
    S_DISP    = 4'd2,
    S_ENTRY   = 4'd3,
    S_L1_ADDR = 4'd4,
    S_L1_DATA = 4'd5,
    S_L2_ADDR = 4'd6,
    S_L2_DATA = 4'd7
  } lcd_state_t;

  // Blanked characters (display off or blink-hidden) become a space.
  function automatic logic [7:0] char_byte(input logic en, input logic blink_hit,
                                           input logic [7:0] ch);
    if (!en || blink_hit) return LCD_SPACE;
    return ch;
  endfunction

endpackage

// File: rtl/lcd_bus_xfer.sv
// One LCD bus transaction of CLK_DIV cycles: RS/DATA stable from cycle 0,
// E high on cycles 1..E_HIGH when strobed. Comes out of reset already in an unstrobed transaction.
module lcd_bus_xfer #(
  parameter int unsigned CLK_DIV = 10,
  parameter int unsigned E_HIGH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tx_strobe,
  input  logic       tx_rs,
  input  logic [7:0] tx_data,
  output logic       e,
  output logic       rs,
  output logic [7:0] data,
  output logic       first,
  output logic       pre_done,
  output logic       done
);

  localparam int unsigned CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLK_DIV - 2);

  logic [CW-1:0] cnt, cnt_nxt;
  logic          active, act_nxt;
  logic          strobe, strobe_nxt;
  logic          load;

  // Next transaction cycle; a start on the last cycle chains with no gap.
  always_comb begin
    cnt_nxt    = cnt;
    act_nxt    = active;
    strobe_nxt = strobe;
    load       = 1'b0;
    if (active && cnt != LAST) begin
      cnt_nxt = cnt + CW'(1);
    end else if (start) begin
      load       = 1'b1;
      cnt_nxt    = '0;
      act_nxt    = 1'b1;
      strobe_nxt = tx_strobe;
    end else begin
      act_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      active   <= 1'b1;
      strobe   <= 1'b0;
      rs       <= 1'b0;
      data     <= 8'h00;
      e        <= 1'b0;
      first    <= 1'b1;
      pre_done <= 1'b0;
      done     <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      active   <= act_nxt;
      strobe   <= strobe_nxt;
      if (load) begin
        rs   <= tx_rs;
        data <= tx_data;
      end
      e        <= act_nxt && strobe_nxt && (cnt_nxt >= CW'(1)) && (cnt_nxt <= CW'(E_HIGH));
      first    <= act_nxt && (cnt_nxt == '0);
      pre_done <= act_nxt && (cnt_nxt == PRE);
      done     <= act_nxt && (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/lcd_char_driver.sv
// 2-line character LCD driver: init sequence, then endless refresh of two
// snapshotted text lines with per-character blinking.
module lcd_char_driver
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 10,
  parameter int unsigned E_HIGH       = 4,
  parameter int unsigned INIT_TICKS   = 20,
  parameter int unsigned COLS         = 16,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [8*COLS-1:0] line1_text,
  input  logic [8*COLS-1:0] line2_text,
  input  logic [2*COLS-1:0] blink_mask,
  input  logic              blink_en,
  output logic              busy,
  output logic              frame_done,
  output logic              LCD_E,
  output logic              LCD_RS,
  output logic              LCD_RW,
  output logic [7:0]        LCD_DATA
);

  localparam int unsigned COLW = $clog2(COLS + 1);
  localparam int unsigned DW   = $clog2(INIT_TICKS + 1);
  localparam int unsigned BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  lcd_state_t        state, nxt_state;
  logic [COLW-1:0]   col, nxt_col;
  logic [DW-1:0]     dly, nxt_dly;
  logic              state_ok;
  logic [BW-1:0]     blink_cnt;
  logic              blink_hidden;
  logic [8*COLS-1:0] l1_snap, l2_snap;
  logic [2*COLS-1:0] mask_snap;
  logic              blen_snap, en_snap;
  logic              x_done, x_pre_done, x_first;
  logic              x_rs, x_strobe;
  logic [7:0]        x_data, ch;
  logic              masked;
  int unsigned       idx;

  assign LCD_RW = 1'b0;

  // Sequencer successor of the transaction currently on the bus.
  always_comb begin
    nxt_state = state;
    nxt_col   = col;
    nxt_dly   = dly;
    state_ok  = 1'b1;
    case (state)
      S_DELAY: begin
        if (dly == DW'(INIT_TICKS - 1)) begin
          nxt_state = S_FUNC;
          nxt_dly   = '0;
        end else begin
          nxt_dly = dly + DW'(1);
        end
      end
      S_FUNC:    nxt_state = S_DISP;
      S_DISP:    nxt_state = S_ENTRY;
      S_ENTRY:   nxt_state = S_L1_ADDR;
      S_L1_ADDR: nxt_state = S_L1_DATA;
      S_L1_DATA: begin
        if (col == COLW'(COLS - 1)) begin
          nxt_state = S_L2_ADDR;
          nxt_col   = '0;
        end else begin
          nxt_col = col + COLW'(1);
        end
      end
      S_L2_ADDR: nxt_state = S_L2_DATA;
      S_L2_DATA: begin
        if (col == COLW'(COLS - 1)) begin
          nxt_state = S_L1_ADDR;
          nxt_col   = '0;
        end else begin
          nxt_col = col + COLW'(1);
        end
      end
      default: begin
        nxt_state = S_DELAY;
        nxt_col   = '0;
        nxt_dly   = '0;
        state_ok  = 1'b0;
      end
    endcase
  end

  // Bus payload for the successor transaction, taken only from the snapshot.
  always_comb begin
    x_rs     = 1'b0;
    x_data   = 8'h00;
    x_strobe = 1'b1;
    idx      = 32'(nxt_col);
    ch       = (nxt_state == S_L2_DATA) ? l2_snap[8*idx +: 8] : l1_snap[8*idx +: 8];
    masked   = (nxt_state == S_L2_DATA) ? mask_snap[COLS + idx] : mask_snap[idx];
    case (nxt_state)
      S_DELAY:   x_strobe = 1'b0;
      S_FUNC:    x_data   = LCD_FUNC_8B2L;
      S_DISP:    x_data   = LCD_DISP_ON;
      S_ENTRY:   x_data   = LCD_ENTRY_INC;
      S_L1_ADDR: x_data   = LCD_LINE1;
      S_L2_ADDR: x_data   = LCD_LINE2;
      S_L1_DATA, S_L2_DATA: begin
        x_rs   = 1'b1;
        x_data = char_byte(en_snap, blen_snap && masked && blink_hidden, ch);
      end
      default:   x_strobe = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_DELAY;
      col          <= '0;
      dly          <= '0;
      busy         <= 1'b1;
      frame_done   <= 1'b0;
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
      l1_snap      <= '0;
      l2_snap      <= '0;
      mask_snap    <= '0;
      blen_snap    <= 1'b0;
      en_snap      <= 1'b0;
    end else if (!state_ok) begin
      state        <= S_DELAY;
      col          <= '0;
      dly          <= '0;
      busy         <= 1'b1;
      frame_done   <= 1'b0;
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
    end else begin
      frame_done <= x_pre_done && (state == S_L2_DATA) && (col == COLW'(COLS - 1));
      if (frame_done) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt    <= '0;
          blink_hidden <= ~blink_hidden;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
      if (x_first && state == S_L1_ADDR) begin
        l1_snap   <= line1_text;
        l2_snap   <= line2_text;
        mask_snap <= blink_mask;
        blen_snap <= blink_en;
        en_snap   <= enable;
      end
      if (x_done) begin
        state <= nxt_state;
        col   <= nxt_col;
        dly   <= nxt_dly;
        if (state == S_ENTRY) busy <= 1'b0;
      end
    end
  end

  lcd_bus_xfer #(.CLK_DIV(CLK_DIV), .E_HIGH(E_HIGH)) u_xfer (
    .clk      (clk),
    .rst      (rst),
    .start    (x_done),
    .tx_strobe(x_strobe),
    .tx_rs    (x_rs),
    .tx_data  (x_data),
    .e        (LCD_E),
    .rs       (LCD_RS),
    .data     (LCD_DATA),
    .first    (x_first),
    .pre_done (x_pre_done),
    .done     (x_done)
  );

endmodule

// File: tb/tb_lcd_char_driver.sv
// Scoreboard bench for lcd_char_driver: expected bus bytes are queued per
// frame and popped by a per-transaction bus monitor.
module tb_lcd_char_driver;

  localparam int COLS   = 16;
  localparam int BLINK  = 2;
  localparam int CDIV   = 10;
  localparam int T_INIT = 200;
  localparam int T_BUSY = 230;
  localparam int T_FRM  = 340;

  logic              clk, rst;
  logic              enable, blink_en;
  logic [8*COLS-1:0] line1_text, line2_text;
  logic [2*COLS-1:0] blink_mask;
  logic              busy, frame_done, LCD_E, LCD_RS, LCD_RW;
  logic [7:0]        LCD_DATA;

  int          checks = 0;
  int          failures = 0;
  int          cyc;
  int          nf;
  logic [8:0]  sb_q[$];

  lcd_char_driver #(
    .CLK_DIV(CDIV), .E_HIGH(4), .INIT_TICKS(20), .COLS(COLS), .BLINK_FRAMES(BLINK)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .line1_text(line1_text),
    .line2_text(line2_text), .blink_mask(blink_mask), .blink_en(blink_en),
    .busy(busy), .frame_done(frame_done), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index within the current post-reset run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int fs(input int k);
    return T_BUSY + T_FRM * k;
  endfunction

  function automatic logic [8*COLS-1:0] to_line(input string s);
    logic [8*COLS-1:0] v;
    for (int i = 0; i < COLS; i++) v[8*i +: 8] = (i < s.len()) ? s[i] : 8'h20;
    return v;
  endfunction

  task automatic goto_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive the inputs for frame nf and queue the bytes it must produce.
  task automatic frame_begin(input logic [8*COLS-1:0] l1, input logic [8*COLS-1:0] l2,
                             input logic [2*COLS-1:0] m, input logic be, input logic en);
    logic       hidden;
    logic [7:0] b;
    line1_text = l1;
    line2_text = l2;
    blink_mask = m;
    blink_en   = be;
    enable     = en;
    hidden     = ((nf / BLINK) % 2) == 1;
    sb_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < COLS; i++) begin
      b = !en ? 8'h20 : (be && m[i] && hidden) ? 8'h20 : l1[8*i +: 8];
      sb_q.push_back({1'b1, b});
    end
    sb_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < COLS; i++) begin
      b = !en ? 8'h20 : (be && m[COLS+i] && hidden) ? 8'h20 : l2[8*i +: 8];
      sb_q.push_back({1'b1, b});
    end
  endtask

  task automatic frame_sync();
    goto_cyc(fs(nf) + 1);
    nf++;
  endtask

  // Per-transaction bus checker: E shape, stability, busy, frame_done, bytes.
  task automatic monitor();
    logic       cap_rs, stable;
    logic [7:0] cap_d;
    logic [9:0] ep, fp, exp_ep, exp_fp;
    logic [8:0] exp_w;
    int         ph;
    cap_rs = 1'b0; cap_d = 8'h00; stable = 1'b0; ep = '0; fp = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ph = cyc % CDIV;
        if (ph == 0) begin
          cap_rs = LCD_RS; cap_d = LCD_DATA; stable = 1'b1; ep = '0; fp = '0;
          checks++;
          if (busy !== (cyc < T_BUSY)) begin
            failures++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, cyc < T_BUSY);
          end
        end else if (LCD_RS !== cap_rs || LCD_DATA !== cap_d) begin
          stable = 1'b0;
        end
        ep[ph] = LCD_E;
        fp[ph] = frame_done;
        if (ph == CDIV - 1) begin
          exp_ep = (cyc < T_INIT) ? 10'b0 : 10'b0000011110;
          checks++;
          if (ep !== exp_ep) begin
            failures++;
            $display("FAIL e_shape cyc=%0d got=%b exp=%b", cyc, ep, exp_ep);
          end
          checks++;
          if (stable !== 1'b1 || LCD_RW !== 1'b0) begin
            failures++;
            $display("FAIL bus_stable cyc=%0d stable=%b rw=%b exp stable=1 rw=0", cyc, stable, LCD_RW);
          end
          exp_fp = (cyc >= T_BUSY && (cyc - T_BUSY) % T_FRM == T_FRM - 1) ? 10'b1000000000 : 10'b0;
          checks++;
          if (fp !== exp_fp) begin
            failures++;
            $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, fp, exp_fp);
          end
          if (cyc < T_INIT) begin
            exp_w = 9'h000;
          end else if (sb_q.size() == 0) begin
            exp_w = 9'h1FF;
            $display("FAIL sb_empty cyc=%0d got=%h exp=<none queued>", cyc, {cap_rs, cap_d});
            failures++;
          end else begin
            exp_w = sb_q.pop_front();
          end
          checks++;
          if ({cap_rs, cap_d} !== exp_w) begin
            failures++;
            $display("FAIL byte cyc=%0d got rs=%b data=%h exp rs=%b data=%h",
                     cyc, cap_rs, cap_d, exp_w[8], exp_w[7:0]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({LCD_E, LCD_RS, LCD_RW, LCD_DATA} !== 11'h0) begin
      failures++;
      $display("FAIL reset_bus got e=%b rs=%b rw=%b data=%h exp all 0", LCD_E, LCD_RS, LCD_RW, LCD_DATA);
    end
    checks++;
    if (busy !== 1'b1 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got busy=%b fd=%b exp busy=1 fd=0", busy, frame_done);
    end
    rst = 1'b0;
    nf  = 0;
    sb_q.push_back({1'b0, 8'h38});
    sb_q.push_back({1'b0, 8'h0C});
    sb_q.push_back({1'b0, 8'h06});
  endtask

  task automatic test_text();
    logic [8*COLS-1:0] r1, r2;
    frame_begin(to_line("TIMER MODE"), to_line("TIME SET : 12:34"), '0, 1'b0, 1'b1);
    frame_sync();
    for (int i = 0; i < COLS; i++) begin
      r1[8*i +: 8] = 8'($urandom_range(0, 255));
      r2[8*i +: 8] = 8'($urandom_range(0, 255));
    end
    frame_begin(r1, r2, '1, 1'b0, 1'b1);
    frame_sync();
  endtask

  task automatic test_enable();
    frame_begin(to_line("TIMER MODE"), to_line("TIME SET : 12:34"), '0, 1'b0, 1'b0);
    frame_sync();
  endtask

  task automatic test_snapshot();
    logic [8*COLS-1:0] l1;
    l1 = to_line("TIMER MODE");
    frame_begin(l1, to_line("TIME SET : 12:34"), '0, 1'b0, 1'b1);
    frame_sync();
    goto_cyc(fs(nf - 1) + 65);
    l1[7:0] = 8'h58;
    frame_begin(l1, to_line("TIME SET : 12:34"), '0, 1'b0, 1'b1);
    frame_sync();
  endtask

  task automatic test_blink();
    logic [2*COLS-1:0] m;
    m = '0;
    m[27] = 1'b1;
    for (int f = 0; f < 4; f++) begin
      frame_begin(to_line("TIMER MODE"), to_line("TIME SET : 12:34"), m, 1'b1, 1'b1);
      frame_sync();
    end
    frame_begin(to_line("ABCDEFGHIJKLMNOP"), to_line("0123456789abcdef"), '1, 1'b1, 1'b1);
    frame_sync();
  endtask

  task automatic test_reset_mid();
    goto_cyc(fs(nf - 1) + 32);
    checks++;
    if (LCD_E !== 1'b1) begin
      failures++;
      $display("FAIL pre_rst_e got=%b exp=1", LCD_E);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({LCD_E, LCD_RS, LCD_DATA} !== 10'h0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL async_rst got e=%b rs=%b data=%h busy=%b exp 0/0/00/1", LCD_E, LCD_RS, LCD_DATA, busy);
    end
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    nf  = 0;
    sb_q.push_back({1'b0, 8'h38});
    sb_q.push_back({1'b0, 8'h0C});
    sb_q.push_back({1'b0, 8'h06});
    frame_begin(to_line("AFTER RESET"), to_line("TIME SET : 12:34"), '0, 1'b0, 1'b1);
    frame_sync();
    goto_cyc(fs(nf - 1) + T_FRM + 1);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d left exp=0", sb_q.size());
    end
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    blink_en   = 1'b0;
    line1_text = '0;
    line2_text = '0;
    blink_mask = '0;
    nf         = 0;
    fork
      monitor();
    join_none
    test_reset();
    test_text();
    test_enable();
    test_snapshot();
    test_blink();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_char_driver.md
Name: lcd_char_driver

Overview:
Parametrised successor of the fixed-text timer LCD block: drives an HD44780-class 2-line character LCD in 8-bit write-only mode from two generic frame-buffer inputs instead of hard-coded strings.
- Adds a proper E strobe with setup and hold around stable RS/DATA.
- Adds per-frame snapshotting of the text inputs to prevent tearing.
- Adds per-character blinking, a frame_done pulse and a busy flag.
- Sits between the mode/timer logic, which formats text, and the LCD pins.

Parameters:
CLK_DIV, 10, clk cycles per bus transaction; must be >= E_HIGH+2.
E_HIGH, 4, cycles LCD_E is held high within a transaction; must be >= 1.
INIT_TICKS, 20, idle transactions (LCD_E low, DATA=0x00) after reset before the first command.
COLS, 16, characters per line; legal range 1..40.
BLINK_FRAMES, 8, frames per blink half-period; must be >= 1.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
enable  in  1  1: show text; 0: all data bytes forced to 0x20
line1_text  in  8*COLS  line 1 ASCII; char 0 (leftmost) = bits [7:0]
line2_text  in  8*COLS  line 2 ASCII; same ordering
blink_mask  in  2*COLS  bit i<COLS = line1 char i; bit COLS+i = line2 char i
blink_en  in  1  global blink enable
busy  out  1  high from reset until the third init command completes
frame_done  out  1  one-cycle pulse at the end of each frame
LCD_E  out  1  enable strobe
LCD_RS  out  1  0 = command, 1 = data
LCD_RW  out  1  tied to 0 (write only)
LCD_DATA  out  8  command or character byte

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, busy=1, frame_done=0, blink phase = visible, all counters 0, state S_DELAY.
- Transaction timing: each transaction lasts exactly CLK_DIV cycles, numbered 0..CLK_DIV-1.
  - RS and DATA update at cycle 0 and stay stable for the whole transaction.
  - LCD_E=1 during cycles 1..E_HIGH and 0 otherwise.
  - LCD_RW is always 0.
- FSM states, one transaction each unless noted:
  - S_DELAY: INIT_TICKS transactions, E held low throughout.
  - S_FUNC: 0x38. S_DISP: 0x0C. S_ENTRY: 0x06. busy deasserts on the cycle after S_ENTRY's last cycle.
  - S_L1_ADDR: 0x80. S_L1_DATA: COLS data transactions. S_L2_ADDR: 0xC0. S_L2_DATA: COLS data transactions. Then back to S_L1_ADDR.
  - Init runs once per reset.
- Frame length: 2+2*COLS transactions.
- frame_done: pulses during the final cycle of the last S_L2_DATA transaction.
- Snapshot: on cycle 0 of S_L1_ADDR the block registers line1_text, line2_text, blink_mask, blink_en and enable. The frame uses only the snapshot; input changes mid-frame take effect in the next frame.
- Data byte selection (RS=1), in priority order:
  - enable_snap=0 -> 0x20.
  - blink_en_snap=1 and the char's mask bit is set and blink phase = hidden -> 0x20.
  - Otherwise the snapshot character, passed verbatim with no validation.
- Blink phase: a frame counter 0..BLINK_FRAMES-1 increments at each frame_done. On wrap the phase toggles. The counter keeps running when blink_en=0.
- Counter widths: transaction counter $clog2(CLK_DIV); column counter $clog2(COLS+1); delay counter $clog2(INIT_TICKS+1). All wrap only by explicit compare, never by natural overflow.
- Reset mid-operation: all outputs go to reset values immediately (asynchronously), even if E is high, and init restarts from S_DELAY.
- Illegal state: recover to S_DELAY with reset values.

Decomposition:
- Shared package/include lcd_pkg: command constants (LCD_FUNC_8B2L=0x38, LCD_DISP_ON=0x0C, LCD_ENTRY_INC=0x06, LCD_LINE1=0x80, LCD_LINE2=0xC0, LCD_SPACE=0x20) and state encodings. Also reused by the ASCII formatters.
- One sub-module, lcd_bus_xfer: owns CLK_DIV/E_HIGH timing and drives LCD_E.
  - Handshake: start (1 cycle) with rs/data -> registers them, runs one transaction, pulses done during its last cycle.
  - Back-to-back start on the done cycle is legal.
- The parent holds the FSM, snapshot registers and blink logic.

Test Plan:
1. Defaults, release rst at t=0 -> E low for 200 clks; then 0x38, 0x0C, 0x06 with RS=0, one per 10 clks, E high exactly clks 1-4 of each; busy falls at clk 230.
2. line1="TIMER MODE"+6 spaces, line2="TIME SET : 12:34", enable=1 -> 0x80, 16 RS=1 bytes 0x54…0x20, 0xC0, 16 bytes ending 0x33,0x34; frame period 340 clks; exactly one frame_done per frame.
3. enable=0 with text as in 2 -> all 32 data bytes 0x20; the 0x80/0xC0 commands are unchanged.
4. Change line1 char 0 from 'T' to 'X' during line1 col 5 -> current frame still sends 0x54 at col 0; next frame sends 0x58.
5. BLINK_FRAMES=2, blink_en=1, blink_mask bit 27 (line2 col 11) set, line2 col 11='1' -> frames 0-1 send 0x31, frames 2-3 send 0x20, frames 4-5 send 0x31; all other chars unaffected.
6. Assert rst for 3 clks while E is high in S_L1_DATA -> E, RS, DATA go 0 in the same cycle; busy=1; after release, 200 clks of idle and then 0x38.
